// File: rtl/adc_capture_if.sv
// ADC capture bus: serial ADC pins, sample-RAM write port and buffer status.
// Carries trig_level only when OSC_TRIGGER_EN is defined.
interface adc_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
);
    logic              arm;
    logic              adc_data;
    logic              adc_clk;
    logic              adc_conv;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              buf_full;
    logic              busy;
`ifdef OSC_TRIGGER_EN
    logic [DATA_W-1:0] trig_level;

    modport slave (
        input  arm, adc_data, trig_level,
        output adc_clk, adc_conv, write_en, write_addr, write_data, buf_full, busy
    );
    modport master (
        output arm, adc_data, trig_level,
        input  adc_clk, adc_conv, write_en, write_addr, write_data, buf_full, busy
    );
`else
    modport slave (
        input  arm, adc_data,
        output adc_clk, adc_conv, write_en, write_addr, write_data, buf_full, busy
    );
    modport master (
        output arm, adc_data,
        input  adc_clk, adc_conv, write_en, write_addr, write_data, buf_full, busy
    );
`endif
endinterface

// File: rtl/adc_capture_ctrl.sv
// Serial ADC reader: generates adc_clk/adc_conv, deserialises frames and streams a
// DATA_W field into sample RAM. Optional level trigger under OSC_TRIGGER_EN.
module adc_capture_ctrl #(
    parameter int CLK_DIV    = 64,
    parameter int FRAME_BITS = 16,
    parameter int MSB_POS    = 13,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 25000,
    parameter int ADDR_W     = 15
) (
    input  logic          osc_clk,
    input  logic          reset,
    adc_capture_if.slave  bus
);
    localparam int DW  = $clog2(CLK_DIV);
    localparam int BCW = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_SHIFT, S_STORE, S_FULL
`ifdef OSC_TRIGGER_EN
        , S_ARMED
`endif
    } state_t;

    state_t            r_state;
    logic [DW-1:0]     r_div;
    logic              r_adc_clk;
    logic              r_conv;
    logic [BCW-1:0]    r_bit;
    // Bits above MSB_POS never reach the output, so only the low MSB_POS bits are kept.
    logic [MSB_POS-1:0] r_shreg;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_full;
    logic              r_busy;

    logic              w_rise, w_fall, w_store_ok;
    logic [DW-1:0]     w_div_nxt;
    logic [MSB_POS:0]  w_shreg_nxt;
    logic [DATA_W-1:0] w_sample;

    assign w_rise      = (r_div == DW'(CLK_DIV/2 - 1));
    assign w_fall      = (r_div == DW'(CLK_DIV - 1));
    assign w_div_nxt   = w_fall ? '0 : r_div + 1'b1;
    assign w_shreg_nxt = {r_shreg, bus.adc_data};
    assign w_sample    = w_shreg_nxt[MSB_POS -: DATA_W];

`ifdef OSC_TRIGGER_EN
    logic              r_trig_wait;
    logic              r_have_prev;
    logic [DATA_W-1:0] r_prev;
    // Rising crossing of trig_level; the first frame after arm has no history.
    assign w_store_ok = !r_trig_wait ||
                        (r_have_prev && (r_prev < bus.trig_level) && (w_sample >= bus.trig_level));
`else
    assign w_store_ok = 1'b1;
`endif

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_adc_clk <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_adc_clk <= (w_div_nxt >= DW'(CLK_DIV/2));
        end
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_conv  <= 1'b0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_ptr   <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef OSC_TRIGGER_EN
            r_trig_wait <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev      <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_IDLE, S_FULL: begin
                    if (bus.arm) begin
                        r_ptr   <= '0;
                        r_waddr <= '0;
                        r_full  <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef OSC_TRIGGER_EN
                        r_trig_wait <= 1'b1;
                        r_have_prev <= 1'b0;
                        r_state     <= S_ARMED;
`else
                        r_state <= S_CONV;
`endif
                    end
                end
                S_CONV
`ifdef OSC_TRIGGER_EN
                , S_ARMED
`endif
                : begin
                    if (w_fall) begin
                        if (!r_conv) begin
                            r_conv <= 1'b1;
                        end else begin
                            r_conv  <= 1'b0;
                            r_bit   <= '0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_rise) begin
                        r_shreg <= w_shreg_nxt[MSB_POS-1:0];
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == BCW'(FRAME_BITS - 1)) begin
`ifdef OSC_TRIGGER_EN
                            if (r_trig_wait) begin
                                r_prev      <= w_sample;
                                r_have_prev <= 1'b1;
                            end
`endif
                            if (w_store_ok) begin
                                r_wen   <= 1'b1;
                                r_wdata <= w_sample;
                                r_waddr <= r_ptr;
                                r_state <= S_STORE;
`ifdef OSC_TRIGGER_EN
                                r_trig_wait <= 1'b0;
`endif
                            end
`ifdef OSC_TRIGGER_EN
                            else r_state <= S_ARMED;
`endif
                        end
                    end
                end
                S_STORE: begin
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_full  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FULL;
                    end else begin
                        r_ptr   <= r_ptr + 1'b1;
                        // With CLK_DIV=2 this cycle is itself a fall; don't lose the frame start.
                        r_conv  <= w_fall;
                        r_state <= S_CONV;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.adc_clk    = r_adc_clk;
    assign bus.adc_conv   = r_conv;
    assign bus.write_en   = r_wen;
    assign bus.write_addr = r_waddr;
    assign bus.write_data = r_wdata;
    assign bus.buf_full   = r_full;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: two instances (MSB_POS 13 and 15), behavioural ADC.
// Define OSC_TRIGGER_EN to run the trigger scenario instead of the fill scenarios.
module tb_adc_capture_ctrl;
    logic osc_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 osc_clk = ~osc_clk;
    always @(posedge osc_clk) cyc <= cyc + 1;

    adc_capture_if #(.DATA_W(8), .ADDR_W(8)) b1 ();
    adc_capture_if #(.DATA_W(8), .ADDR_W(8)) b2 ();

    adc_capture_ctrl #(.CLK_DIV(4), .FRAME_BITS(16), .MSB_POS(13), .DATA_W(8),
                       .DEPTH(4), .ADDR_W(8))
        u_dut (.osc_clk(osc_clk), .reset(reset), .bus(b1));

    adc_capture_ctrl #(.CLK_DIV(4), .FRAME_BITS(16), .MSB_POS(15), .DATA_W(8),
                       .DEPTH(4), .ADDR_W(8))
        u_dut2 (.osc_clk(osc_clk), .reset(reset), .bus(b2));

    // ADC models: load a frame while adc_conv is high, step one bit per adc_clk rise.
    logic [15:0] frames [8];
    int          nfr = 1;
    int          fidx = 0;
    logic [15:0] fcur = 16'h0;
    int          bidx = 15;
    logic        pconv = 1'b0, pclk = 1'b0;
    int          bidx2 = 15;
    logic        pclk2 = 1'b0;
    localparam logic [15:0] FRAME2 = 16'hA5FF;

    always @(negedge osc_clk) begin
        if (b1.adc_conv && !pconv) begin
            fcur = frames[fidx];
            if (fidx < nfr - 1) fidx = fidx + 1;
        end
        if (b1.adc_conv) bidx = 15;
        else if (b1.adc_clk && !pclk && bidx > 0) bidx = bidx - 1;
        b1.adc_data = fcur[bidx];
        pconv = b1.adc_conv;
        pclk  = b1.adc_clk;

        if (b2.adc_conv) bidx2 = 15;
        else if (b2.adc_clk && !pclk2 && bidx2 > 0) bidx2 = bidx2 - 1;
        b2.adc_data = FRAME2[bidx2];
        pclk2 = b2.adc_clk;
    end

    // Write / buf_full monitor
    logic [7:0] q1a[$], q1d[$], q2a[$], q2d[$];
    int         q1c[$];
    int         full_cyc = -1;
    logic       pfull = 1'b0;

    always @(negedge osc_clk) begin
        if (b1.write_en) begin
            q1a.push_back(b1.write_addr);
            q1d.push_back(b1.write_data);
            q1c.push_back(cyc);
        end
        if (b1.buf_full && !pfull) full_cyc = cyc;
        pfull = b1.buf_full;
        if (b2.write_en) begin
            q2a.push_back(b2.write_addr);
            q2d.push_back(b2.write_data);
        end
    end

    task automatic tick();
        @(negedge osc_clk);
        #1;
    endtask

    task automatic clear_q();
        q1a.delete(); q1d.delete(); q1c.delete(); q2a.delete(); q2d.delete();
        full_cyc = -1;
    endtask

    task automatic wait_q1(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (q1a.size() < n && i < budget) begin
            tick();
            i++;
        end
        ok = (q1a.size() >= n);
    endtask

    task automatic pulse_arm1();
        b1.arm = 1'b1;
        tick();
        b1.arm = 1'b0;
    endtask

    task automatic test_reset();
        logic any_conv;
        logic exp_clk;
        b1.arm = 1'b0;
        b2.arm = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({b1.adc_clk, b1.adc_conv, b1.write_en, b1.buf_full, b1.busy,
             b1.write_addr, b1.write_data} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got clk=%b conv=%b we=%b full=%b busy=%b addr=%0h data=%0h want all 0",
                     b1.adc_clk, b1.adc_conv, b1.write_en, b1.buf_full, b1.busy, b1.write_addr, b1.write_data);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_clk = ((k % 4) >= 2);
            total++;
            if (b1.adc_clk !== exp_clk) begin
                bad++;
                $display("FAIL adc_clk_phase k=%0d: got %b want %b", k, b1.adc_clk, exp_clk);
            end
        end
        any_conv = 1'b0;
        for (int k = 0; k < 192; k++) begin
            tick();
            any_conv |= b1.adc_conv | b1.busy;
        end
        total++;
        if (q1a.size() !== 0 || any_conv !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got writes=%0d conv_or_busy=%b want 0 and 0", q1a.size(), any_conv);
        end
    endtask

    task automatic test_fill();
        bit ok;
        clear_q();
        pulse_arm1();
        wait_q1(4, 2000, ok);
        repeat (2) tick();
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fill_timeout: got %0d writes want 4", q1a.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q1a[i] !== 8'(i) || q1d[i] !== 8'h7F) begin
                bad++;
                $display("FAIL fill_write%0d: got addr=%0d data=%0h want addr=%0d data=7f", i, q1a[i], q1d[i], i);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (q1c[i] - q1c[i-1] !== 68) begin
                bad++;
                $display("FAIL fill_spacing%0d: got %0d want 68", i, q1c[i] - q1c[i-1]);
            end
        end
        total++;
        if (full_cyc !== q1c[3] + 1 || b1.buf_full !== 1'b1 || b1.busy !== 1'b0) begin
            bad++;
            $display("FAIL buf_full_rise: got rise_cyc=%0d full=%b busy=%b want rise_cyc=%0d full=1 busy=0",
                     full_cyc, b1.buf_full, b1.busy, q1c[3] + 1);
        end
    endtask

    task automatic test_field();
        int i;
        b2.arm = 1'b1;
        tick();
        b2.arm = 1'b0;
        i = 0;
        while (q2a.size() < 1 && i < 500) begin
            tick();
            i++;
        end
        total++;
        if (q2a.size() < 1) begin
            bad++;
            $display("FAIL field_timeout: got no write want 1");
        end else if (q2d[0] !== 8'hA5 || q2a[0] !== 8'd0) begin
            bad++;
            $display("FAIL field_extract: got addr=%0d data=%0h want addr=0 data=a5", q2a[0], q2d[0]);
        end
    endtask

    task automatic test_rearm();
        bit ok;
        clear_q();
        pulse_arm1();
        total++;
        if (b1.buf_full !== 1'b0 || b1.busy !== 1'b1) begin
            bad++;
            $display("FAIL rearm_status: got full=%b busy=%b want full=0 busy=1", b1.buf_full, b1.busy);
        end
        wait_q1(2, 1000, ok);
        b1.arm = 1'b1;
        repeat (3) tick();
        b1.arm = 1'b0;
        wait_q1(4, 1000, ok);
        repeat (150) tick();
        total++;
        if (!ok || q1a.size() !== 4 || q1a[2] !== 8'd2 || q1a[3] !== 8'd3 || b1.buf_full !== 1'b1) begin
            bad++;
            $display("FAIL arm_midfill: got writes=%0d last_addr=%0d full=%b want writes=4 last_addr=3 full=1",
                     q1a.size(), (q1a.size() > 0) ? q1a[q1a.size()-1] : 8'hFF, b1.buf_full);
        end
        clear_q();
        pulse_arm1();
        total++;
        if (b1.buf_full !== 1'b0) begin
            bad++;
            $display("FAIL rearm_full_drop: got full=%b want 0", b1.buf_full);
        end
        wait_q1(1, 500, ok);
        total++;
        if (!ok || q1a[0] !== 8'd0) begin
            bad++;
            $display("FAIL rearm_addr0: got ok=%0d addr=%0d want ok=1 addr=0", ok, ok ? q1a[0] : 8'hFF);
        end
    endtask

    task automatic test_mid_reset();
        bit   ok;
        int   i;
        int   rises;
        logic pc;
        i = 0;
        while (b1.adc_conv !== 1'b1 && i < 200) begin tick(); i++; end
        while (b1.adc_conv !== 1'b0 && i < 400) begin tick(); i++; end
        rises = 0;
        pc = b1.adc_clk;
        while (rises < 7 && i < 600) begin
            tick();
            i++;
            if (b1.adc_clk && !pc) rises++;
            pc = b1.adc_clk;
        end
        total++;
        if (rises != 7) begin
            bad++;
            $display("FAIL midreset_reach: got rises=%0d want 7", rises);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({b1.adc_clk, b1.adc_conv, b1.write_en, b1.buf_full, b1.busy,
             b1.write_addr, b1.write_data} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got clk=%b conv=%b we=%b busy=%b addr=%0h data=%0h want all 0",
                     b1.adc_clk, b1.adc_conv, b1.write_en, b1.busy, b1.write_addr, b1.write_data);
        end
        clear_q();
        repeat (10) tick();
        total++;
        if (q1a.size() !== 0) begin
            bad++;
            $display("FAIL midreset_nowrite: got writes=%0d want 0", q1a.size());
        end
        reset = 1'b0;
        tick();
        pulse_arm1();
        wait_q1(1, 500, ok);
        total++;
        if (!ok || q1a[0] !== 8'd0 || q1d[0] !== 8'h7F) begin
            bad++;
            $display("FAIL midreset_first: got ok=%0d addr=%0d data=%0h want ok=1 addr=0 data=7f",
                     ok, ok ? q1a[0] : 8'hFF, ok ? q1d[0] : 8'hFF);
        end
    endtask

`ifdef OSC_TRIGGER_EN
    task automatic test_trigger();
        bit ok;
        reset = 1'b1;
        repeat (2) tick();
        frames[0] = 16'h2400;
        frames[1] = 16'h0400;
        frames[2] = 16'h1000;
        frames[3] = 16'h2140;
        frames[4] = 16'h0800;
        nfr  = 5;
        fidx = 0;
        b1.trig_level = 8'h80;
        reset = 1'b0;
        clear_q();
        tick();
        pulse_arm1();
        total++;
        if (b1.busy !== 1'b1) begin
            bad++;
            $display("FAIL armed_busy: got %b want 1", b1.busy);
        end
        wait_q1(2, 3000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL trig_timeout: got %0d writes want 2", q1a.size());
            return;
        end
        total++;
        if (q1a[0] !== 8'd0 || q1d[0] !== 8'h85) begin
            bad++;
            $display("FAIL trig_first: got addr=%0d data=%0h want addr=0 data=85", q1a[0], q1d[0]);
        end
        total++;
        if (q1a[1] !== 8'd1 || q1d[1] !== 8'h20 || q1c[1] - q1c[0] !== 68) begin
            bad++;
            $display("FAIL trig_second: got addr=%0d data=%0h gap=%0d want addr=1 data=20 gap=68",
                     q1a[1], q1d[1], q1c[1] - q1c[0]);
        end
    endtask
`endif

    initial begin
        frames[0] = 16'h1FC0;
        for (int i = 1; i < 8; i++) frames[i] = 16'h1FC0;
        b1.arm = 1'b0;
        b2.arm = 1'b0;
        b1.adc_data = 1'b0;
        b2.adc_data = 1'b0;
`ifdef OSC_TRIGGER_EN
        b1.trig_level = 8'h80;
        b2.trig_level = 8'h00;
`endif
        test_reset();
`ifdef OSC_TRIGGER_EN
        test_trigger();
`else
        test_fill();
        test_field();
        test_rearm();
        test_mid_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
